// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing the shared multicycle MIPS datapath
module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       iord,
    output logic       memreq,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       aluscra,
    output logic [1:0] aluscrb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
    } state_t;
    state_t st, nx;
    assign state = st;
    always_ff @(posedge clk)
        st <= reset ? FETCH : nx;
    always_comb begin
        nx = FETCH;
        iord = 1'b0;
        memreq = 1'b0;
        memwrite = 1'b0;
        irwrite = 1'b0;
        pcwrite = 1'b0;
        branch = 1'b0;
        pcsrc = 2'b00;
        aluscra = 1'b0;
        aluscrb = 2'b00;
        aluop = 2'b00;
        regdst = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    memreq = 1'b1;
                    aluscrb = 2'b01;
                    irwrite = memready;
                    pcwrite = memready;
                    nx = memready ? DECODE : FETCH;
                end
                DECODE: begin
                    aluscrb = 2'b11;
                    nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                         (op == OP_RTYPE) ? EXECUTE :
                         (op == OP_BEQ) ? BRANCH :
                         (op == OP_ADDI) ? ADDIEXEC :
                         (op == OP_J) ? JUMP : FETCH;
                    illegal_op = (nx == FETCH);
                    instr_done = (nx == FETCH);
                end
                MEMADR: begin
                    aluscra = 1'b1;
                    aluscrb = 2'b10;
                    nx = (op == OP_SW) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    memreq = 1'b1;
                    iord = 1'b1;
                    nx = memready ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    memreq = 1'b1;
                    iord = 1'b1;
                    memwrite = 1'b1;
                    instr_done = memready;
                    nx = memready ? FETCH : MEMWRITE;
                end
                EXECUTE: begin
                    aluscra = 1'b1;
                    aluop = 2'b10;
                    nx = ALUWB;
                end
                ALUWB: begin
                    regdst = 1'b1;
                    regwrite = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    aluscra = 1'b1;
                    aluop = 2'b01;
                    pcsrc = 2'b01;
                    branch = 1'b1;
                    instr_done = 1'b1;
                end
                ADDIEXEC: begin
                    aluscra = 1'b1;
                    aluscrb = 2'b10;
                    nx = ADDIWB;
                end
                ADDIWB: begin
                    regwrite = 1'b1;
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pcsrc = 2'b10;
                    pcwrite = 1'b1;
                    instr_done = 1'b1;
                end
                default: nx = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scoreboard bench for the multicycle controller FSM
module tb_multicycle_controller;
    typedef struct packed {
        logic [3:0] state;
        logic       iord, memreq, memwrite, irwrite, pcwrite, branch;
        logic [1:0] pcsrc;
        logic       aluscra;
        logic [1:0] aluscrb, aluop;
        logic       regdst, memtoreg, regwrite, instr_done, illegal_op;
    } ov_t;

    logic clk, reset, memready;
    logic [5:0] op;
    logic iord, memreq, memwrite, irwrite, pcwrite, branch, aluscra;
    logic regdst, memtoreg, regwrite, instr_done, illegal_op;
    logic [1:0] pcsrc, aluscrb, aluop;
    logic [3:0] state;
    ov_t obs;
    ov_t q[$];
    int tests = 0;
    int fails = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .iord(iord), .memreq(memreq), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .aluscra(aluscra),
        .aluscrb(aluscrb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    assign obs = '{state, iord, memreq, memwrite, irwrite, pcwrite, branch, pcsrc,
                   aluscra, aluscrb, aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs per state, taken from the controller's state table
    function automatic ov_t model(input logic [3:0] s, input logic mr, input logic [5:0] o, input logic r);
        ov_t e = '0;
        e.state = s;
        if (!r) begin
            case (s)
                4'd0: begin e.memreq = 1; e.aluscrb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
                4'd1: begin
                    e.aluscrb = 2'b11;
                    if (!(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010})) begin
                        e.illegal_op = 1; e.instr_done = 1;
                    end
                end
                4'd2: begin e.aluscra = 1; e.aluscrb = 2'b10; end
                4'd3: begin e.memreq = 1; e.iord = 1; end
                4'd4: begin e.memtoreg = 1; e.regwrite = 1; e.instr_done = 1; end
                4'd5: begin e.memreq = 1; e.iord = 1; e.memwrite = 1; e.instr_done = mr; end
                4'd6: begin e.aluscra = 1; e.aluop = 2'b10; end
                4'd7: begin e.regdst = 1; e.regwrite = 1; e.instr_done = 1; end
                4'd8: begin e.aluscra = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1; e.instr_done = 1; end
                4'd9: begin e.aluscra = 1; e.aluscrb = 2'b10; end
                4'd10: begin e.regwrite = 1; e.instr_done = 1; end
                4'd11: begin e.pcsrc = 2'b10; e.pcwrite = 1; e.instr_done = 1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic step(input string tag, input logic mr, input logic [5:0] o, input logic [3:0] es, input logic r);
        ov_t e;
        @(posedge clk);
        #1;
        memready = mr;
        op = o;
        reset = r;
        q.push_back(model(es, mr, o, r));
        @(negedge clk);
        e = q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s state=%0d: observed %h expected %h", tag, es, obs, e);
        end
        tests++;
        assert (!(regwrite && memwrite) && !(pcwrite && branch)) else begin
            fails++;
            $error("FAIL %s exclusive enables: observed rw=%b mw=%b pw=%b br=%b expected no overlap",
                   tag, regwrite, memwrite, pcwrite, branch);
        end
    endtask

    initial begin
        reset = 1'b1;
        memready = 1'b0;
        op = 6'b000000;
        step("reset", 0, 6'b000000, 4'd0, 1);
        step("reset", 1, 6'b000000, 4'd0, 1);
        step("rtype", 1, 6'b000000, 4'd0, 0);
        step("rtype", 0, 6'b000000, 4'd1, 0);
        step("rtype", 0, 6'b000000, 4'd6, 0);
        step("rtype", 1, 6'b000000, 4'd7, 0);
        step("lw", 1, 6'b100011, 4'd0, 0);
        step("lw", 1, 6'b100011, 4'd1, 0);
        step("lw", 1, 6'b100011, 4'd2, 0);
        step("lw", 0, 6'b100011, 4'd3, 0);
        step("lw", 0, 6'b100011, 4'd3, 0);
        step("lw", 0, 6'b100011, 4'd3, 0);
        step("lw", 1, 6'b100011, 4'd3, 0);
        step("lw", 1, 6'b100011, 4'd4, 0);
        step("sw", 1, 6'b101011, 4'd0, 0);
        step("sw", 1, 6'b101011, 4'd1, 0);
        step("sw", 1, 6'b101011, 4'd2, 0);
        step("sw", 0, 6'b101011, 4'd5, 0);
        step("sw", 0, 6'b101011, 4'd5, 0);
        step("sw", 1, 6'b101011, 4'd5, 0);
        step("beq", 1, 6'b000100, 4'd0, 0);
        step("beq", 1, 6'b000100, 4'd1, 0);
        step("beq", 1, 6'b000100, 4'd8, 0);
        step("j", 1, 6'b000010, 4'd0, 0);
        step("j", 1, 6'b000010, 4'd1, 0);
        step("j", 1, 6'b000010, 4'd11, 0);
        step("illegal", 1, 6'b000001, 4'd0, 0);
        step("illegal", 1, 6'b000001, 4'd1, 0);
        step("addi", 1, 6'b001000, 4'd0, 0);
        step("addi", 0, 6'b001000, 4'd1, 0);
        step("addi", 0, 6'b001000, 4'd9, 0);
        step("addi", 0, 6'b001000, 4'd10, 0);
        step("fetch_wait", 0, 6'b000000, 4'd0, 0);
        step("fetch_wait", 0, 6'b000000, 4'd0, 0);
        step("fetch_wait", 1, 6'b000000, 4'd0, 0);
        step("fetch_wait", 1, 6'b000000, 4'd1, 0);
        step("fetch_wait", 1, 6'b000000, 4'd6, 0);
        step("fetch_wait", 1, 6'b000000, 4'd7, 0);
        step("sw_reset", 1, 6'b101011, 4'd0, 0);
        step("sw_reset", 1, 6'b101011, 4'd1, 0);
        step("sw_reset", 1, 6'b101011, 4'd2, 0);
        step("sw_reset", 0, 6'b101011, 4'd5, 0);
        step("sw_reset", 0, 6'b101011, 4'd5, 1);
        step("after_reset", 1, 6'b000010, 4'd0, 0);
        step("after_reset", 1, 6'b000010, 4'd1, 0);
        step("after_reset", 1, 6'b000010, 4'd11, 0);
        step("after_reset", 1, 6'b000010, 4'd0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy control FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, PC/IR registers.
- Decodes `op` and walks each instruction through fetch, decode, execute, memory and writeback cycles, driving the mux selects and write enables.
- Memory accesses use a `memready` handshake, so a slow memory inserts wait states.
- Supports R-type, lw, sw, beq, addi and j; any other opcode is retired as a no-op.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
op  input  6  opcode from instruction register (IR[31:26])
memready  input  1  memory completes the current access this cycle
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memreq  output  1  memory access request
memwrite  output  1  memory write strobe
irwrite  output  1  IR load enable
pcwrite  output  1  unconditional PC write enable
branch  output  1  conditional PC write enable (ANDed with zero in the datapath)
pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
aluscra  output  1  ALU A select: 0 = PC, 1 = register A
aluscrb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
aluop  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct
regdst  output  1  register file destination: 0 = rt, 1 = rd
memtoreg  output  1  writeback source: 0 = ALUOut, 1 = memory data
regwrite  output  1  register file write enable
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
state  output  4  current state, for debug and verification

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
  - Codes 12-15 are illegal and go to FETCH on the next edge, with no outputs asserted.
- Reset:
  - Rising edge with reset=1 loads state=FETCH.
  - While reset=1, all outputs are 0: memreq, memwrite, irwrite, pcwrite, branch, regwrite, instr_done, illegal_op and all selects.
  - Reset mid-instruction abandons the instruction; no further write enables are asserted.
- All outputs default to 0. Per state:
  - FETCH: memreq=1, iord=0, aluscra=0, aluscrb=01, aluop=00, pcsrc=00. irwrite=pcwrite=memready (Mealy gate). Stay in FETCH while memready=0; go to DECODE when memready=1.
  - DECODE: aluscra=0, aluscrb=11, aluop=00 (precompute branch target).
    - Next state by op: lw/sw -> MEMADR, R-type -> EXECUTE, beq -> BRANCH, addi -> ADDIEXEC, j -> JUMP.
    - Any other op -> FETCH, with illegal_op=1 and instr_done=1 this cycle.
  - MEMADR: aluscra=1, aluscrb=10, aluop=00. Go to MEMREAD if op=lw, MEMWRITE if op=sw.
  - MEMREAD: memreq=1, iord=1. Hold until memready=1, then go to MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Go to FETCH.
  - MEMWRITE: memreq=1, iord=1, memwrite=1, held every cycle until memready=1. The datapath commits exactly once, on the memready cycle. instr_done=memready. Go to FETCH when memready=1.
  - EXECUTE: aluscra=1, aluscrb=00, aluop=10. Go to ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. Go to FETCH.
  - BRANCH: aluscra=1, aluscrb=00, aluop=01, pcsrc=01, branch=1, instr_done=1. Go to FETCH.
  - ADDIEXEC: aluscra=1, aluscrb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Go to FETCH.
  - JUMP: pcsrc=10, pcwrite=1, instr_done=1. Go to FETCH.
- `op` is sampled combinationally in DECODE and MEMADR only. It is stable there because IR is written only in FETCH.
- memready is ignored in states without memreq.
- Latency with memready tied to 1:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
  - illegal opcode = 2 cycles
- Each memory wait cycle adds 1 cycle to the instruction.
- Never assert regwrite and memwrite in the same cycle. Never assert pcwrite and branch in the same cycle.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> state=0; only FETCH outputs active (memreq=1, aluscrb=01); irwrite=pcwrite=1 because memready=1.
- memready=1, op=000000 -> states 0,1,6,7,0; aluop=10 in EXECUTE; regwrite=1 and regdst=1 only in ALUWB; instr_done high 1 cycle, 4 cycles after fetch start.
- op=100011 with memready low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; iord=1 throughout MEMREAD; memtoreg=1 and regwrite=1 in MEMWB only.
- op=101011 with memready low for 2 cycles in MEMWRITE -> memwrite=1 for 3 cycles; instr_done=1 only on the final cycle; regwrite never 1.
- op=000100, then op=000010, then op=000001 -> beq: BRANCH with branch=1, pcsrc=01, aluop=01; j: JUMP with pcwrite=1, pcsrc=10; illegal op: DECODE -> FETCH with illegal_op=1 and instr_done=1.
- Assert reset in MEMWRITE while memready=0 -> memwrite drops to 0 in the same cycle; state=0 after the edge; no instr_done.
